// File: rtl/bus_xfer_ctrl.sv
// Register-transfer initiator for the shared internal bus: IDLE -> DRIVE -> LOAD -> FIN.
// Define XFER_CNT_EN to add the 16-bit completed-transfer counter output XFER_CNT.
module bus_xfer_ctrl #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int SELW = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [SELW-1:0] REQ_SRC,
    input  logic [SELW-1:0] REQ_DST,
    input  logic            REQ_IMM_EN,
    input  logic [DW-1:0]   REQ_IMM,
    output logic [NREG-1:0] E,
    output logic [NREG-1:0] I,
    output logic [DW-1:0]   BUS_OUT,
    output logic            BUS_OE,
    input  logic [DW-1:0]   BUS_IN,
    output logic            DONE,
    output logic            ERR,
    output logic [DW-1:0]   XFER_DATA
`ifdef XFER_CNT_EN
    ,
    output logic [15:0]     XFER_CNT
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, FIN} state_t;

    localparam logic [SELW:0] NREG_LIM = (SELW+1)'(NREG);

    state_t          state_reg, state_next;
    logic [SELW-1:0] src_reg, dst_reg;
    logic            imm_en_reg;
    logic [DW-1:0]   imm_reg;

    logic [SELW-1:0] src_sel, dst_sel;
    logic            imm_en_sel;
    logic [DW-1:0]   imm_sel;
    logic [NREG-1:0] src_dec, dst_dec;
    logic            src_oor, dst_oor, reject;

    logic [NREG-1:0] e_reg, e_next, i_reg, i_next;
    logic [DW-1:0]   bus_out_reg, bus_out_next, xfer_data_reg;
    logic            bus_oe_reg, bus_oe_next;
    logic            done_reg, done_next, err_reg, err_next, ready_reg, ready_next;

    // Outputs are registered from the next state, so the first drive cycle
    // must decode straight from the request inputs rather than the latches.
    assign src_sel    = (state_reg == IDLE) ? REQ_SRC    : src_reg;
    assign dst_sel    = (state_reg == IDLE) ? REQ_DST    : dst_reg;
    assign imm_en_sel = (state_reg == IDLE) ? REQ_IMM_EN : imm_en_reg;
    assign imm_sel    = (state_reg == IDLE) ? REQ_IMM    : imm_reg;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
            assign src_dec[gi] = (src_sel == SELW'(gi));
            assign dst_dec[gi] = (dst_sel == SELW'(gi));
        end
    endgenerate

    assign src_oor = ({1'b0, REQ_SRC} >= NREG_LIM);
    assign dst_oor = ({1'b0, REQ_DST} >= NREG_LIM);
    assign reject  = REQ_IMM_EN ? dst_oor
                                : ((REQ_SRC == REQ_DST) || src_oor || dst_oor);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            imm_en_reg    <= 1'b0;
            imm_reg       <= '0;
            e_reg         <= '0;
            i_reg         <= '0;
            bus_out_reg   <= '0;
            bus_oe_reg    <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            ready_reg     <= 1'b1;
            xfer_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            e_reg       <= e_next;
            i_reg       <= i_next;
            bus_out_reg <= bus_out_next;
            bus_oe_reg  <= bus_oe_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            ready_reg   <= ready_next;
            if (state_reg == IDLE && REQ_VALID) begin
                src_reg    <= REQ_SRC;
                dst_reg    <= REQ_DST;
                imm_en_reg <= REQ_IMM_EN;
                imm_reg    <= REQ_IMM;
            end
            if (state_reg == LOAD) begin
                xfer_data_reg <= BUS_IN;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (REQ_VALID && !reject) state_next = DRIVE;
            DRIVE:   state_next = LOAD;
            LOAD:    state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        e_next       = '0;
        i_next       = '0;
        bus_out_next = '0;
        bus_oe_next  = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        ready_next   = 1'b0;
        case (state_next)
            IDLE: begin
                ready_next = 1'b1;
                err_next   = (state_reg == IDLE) && REQ_VALID && reject;
            end
            DRIVE, LOAD: begin
                if (imm_en_sel) begin
                    bus_oe_next  = 1'b1;
                    bus_out_next = imm_sel;
                end else begin
                    e_next = src_dec;
                end
                if (state_next == LOAD) i_next = dst_dec;
            end
            FIN:     done_next = 1'b1;
            default: ready_next = 1'b0;
        endcase
    end

    assign E         = e_reg;
    assign I         = i_reg;
    assign BUS_OUT   = bus_out_reg;
    assign BUS_OE    = bus_oe_reg;
    assign DONE      = done_reg;
    assign ERR       = err_reg;
    assign REQ_READY = ready_reg;
    assign XFER_DATA = xfer_data_reg;

`ifdef XFER_CNT_EN
    logic [15:0] xfer_cnt_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            xfer_cnt_reg <= '0;
        end else if (state_reg == FIN) begin
            xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
        end
    end

    assign XFER_CNT = xfer_cnt_reg;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed + scoreboard bench for bus_xfer_ctrl: strobe timing, reset abort,
// immediate mode, reject, back-to-back acceptance and random transfers.
module tb_bus_xfer_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_SRC, REQ_DST;
    logic       REQ_IMM_EN;
    logic [7:0] REQ_IMM;
    logic [3:0] E, I;
    logic [7:0] BUS_OUT;
    logic       BUS_OE;
    logic [7:0] BUS_IN;
    logic       DONE, ERR;
    logic [7:0] XFER_DATA;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] reg_val [4] = '{8'h5A, 8'h05, 8'hC3, 8'h77};
    int         n_assert = 0;
    int         n_fail   = 0;
    logic       armed    = 1'b0;

    bus_xfer_ctrl dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_SRC(REQ_SRC), .REQ_DST(REQ_DST), .REQ_IMM_EN(REQ_IMM_EN),
        .REQ_IMM(REQ_IMM), .E(E), .I(I), .BUS_OUT(BUS_OUT), .BUS_OE(BUS_OE),
        .BUS_IN(BUS_IN), .DONE(DONE), .ERR(ERR), .XFER_DATA(XFER_DATA)
    );

    always #5 CLK = ~CLK;

    // Bus model: the immediate driver or whichever register has its E strobe.
    always_comb begin
        BUS_IN = 8'h00;
        if (BUS_OE) BUS_IN = BUS_OUT;
        for (int k = 0; k < 4; k++) begin
            if (E[k]) BUS_IN = reg_val[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] s, input logic [1:0] d,
                            input logic ie, input logic [7:0] im);
        exp_t x;
        x.err  = !ie && (s == d);
        x.data = ie ? im : reg_val[s];
        sb.push_back(x);
    endtask

    task automatic drive_req(input logic [1:0] s, input logic [1:0] d,
                             input logic ie, input logic [7:0] im);
        REQ_VALID  = 1'b1;
        REQ_SRC    = s;
        REQ_DST    = d;
        REQ_IMM_EN = ie;
        REQ_IMM    = im;
        push_exp(s, d, ie, im);
    endtask

    task automatic run_req(input logic [1:0] s, input logic [1:0] d,
                           input logic ie, input logic [7:0] im);
        int n;
        drive_req(s, d, ie, im);
        n = 0;
        while (!REQ_READY && n < 10) begin step(); n++; end
        chk("ready_wait", 32'(REQ_READY), 32'd1);
        step();
        REQ_VALID = 1'b0;
        n = 0;
        while (!DONE && !ERR && n < 8) begin step(); n++; end
        chk("resp_wait", 32'(DONE | ERR), 32'd1);
        $display("txn src=%0d dst=%0d imm_en=%0d imm=%02h done=%0d err=%0d data=%02h",
                 s, d, ie, im, DONE, ERR, XFER_DATA);
        step();
    endtask

    // Invariants and scoreboard, sampled mid-cycle.
    always @(negedge CLK) begin
        exp_t x;
        if (armed) begin
            chk("inv_e_onehot", 32'($onehot0(E)), 32'd1);
            chk("inv_i_onehot", 32'($onehot0(I)), 32'd1);
            chk("inv_e_and_oe", 32'((|E) & BUS_OE), 32'd0);
            chk("inv_i_no_drv", 32'((|I) & ~((|E) | BUS_OE)), 32'd0);
            chk("done_err_excl", 32'(DONE & ERR), 32'd0);
            if (DONE | ERR) begin
                chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    chk("sb_kind_err", 32'(ERR), 32'(x.err));
                    if (!x.err) chk("sb_xfer_data", 32'(XFER_DATA), 32'(x.data));
                end
            end
        end
    end

    initial begin
        RST = 1'b1; REQ_VALID = 1'b0; REQ_SRC = '0; REQ_DST = '0;
        REQ_IMM_EN = 1'b0; REQ_IMM = '0;
        step(); step();
        RST = 1'b0;
        armed = 1'b1;
        chk("rst_e", 32'(E), 32'd0);
        chk("rst_i", 32'(I), 32'd0);
        chk("rst_oe", 32'(BUS_OE), 32'd0);
        chk("rst_bus_out", 32'(BUS_OUT), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_ready", 32'(REQ_READY), 32'd1);
        chk("rst_xfer_data", 32'(XFER_DATA), 32'd0);

        // Register transfer 1 -> 0
        drive_req(2'd1, 2'd0, 1'b0, 8'h00);
        step();
        REQ_VALID = 1'b0;
        chk("reg_c1_e", 32'(E), 32'b0010);
        chk("reg_c1_i", 32'(I), 32'd0);
        chk("reg_c1_ready", 32'(REQ_READY), 32'd0);
        step();
        chk("reg_c2_e", 32'(E), 32'b0010);
        chk("reg_c2_i", 32'(I), 32'b0001);
        step();
        chk("reg_c3_done", 32'(DONE), 32'd1);
        chk("reg_c3_e", 32'(E), 32'd0);
        chk("reg_c3_data", 32'(XFER_DATA), 32'h05);
        $display("txn reg 1->0 data=%02h", XFER_DATA);
        step();
        chk("reg_c4_ready", 32'(REQ_READY), 32'd1);
        chk("reg_c4_done", 32'(DONE), 32'd0);

        // Reset in the middle of LOAD (1 -> 2)
        drive_req(2'd1, 2'd2, 1'b0, 8'h00);
        step();
        REQ_VALID = 1'b0;
        step();
        chk("mid_load_e", 32'(E), 32'b0010);
        chk("mid_load_i", 32'(I), 32'b0100);
        RST = 1'b1;
        step();
        sb.delete();
        chk("abort_e", 32'(E), 32'd0);
        chk("abort_i", 32'(I), 32'd0);
        chk("abort_oe", 32'(BUS_OE), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_ready", 32'(REQ_READY), 32'd1);
        chk("abort_xfer_data", 32'(XFER_DATA), 32'd0);
        step();
        RST = 1'b0;
        step();
        chk("post_abort_e", 32'(E), 32'd0);
        chk("post_abort_done", 32'(DONE), 32'd0);
        $display("txn reset abort mid-load");

        // Immediate FE -> 3
        drive_req(2'd0, 2'd3, 1'b1, 8'hFE);
        step();
        REQ_VALID = 1'b0;
        chk("imm_c1_oe", 32'(BUS_OE), 32'd1);
        chk("imm_c1_bus", 32'(BUS_OUT), 32'hFE);
        chk("imm_c1_e", 32'(E), 32'd0);
        chk("imm_c1_i", 32'(I), 32'd0);
        step();
        chk("imm_c2_oe", 32'(BUS_OE), 32'd1);
        chk("imm_c2_bus", 32'(BUS_OUT), 32'hFE);
        chk("imm_c2_i", 32'(I), 32'b1000);
        step();
        chk("imm_c3_oe", 32'(BUS_OE), 32'd0);
        chk("imm_c3_done", 32'(DONE), 32'd1);
        chk("imm_c3_data", 32'(XFER_DATA), 32'hFE);
        $display("txn imm FE->3 data=%02h", XFER_DATA);
        step();

        // Reject 2 -> 2
        drive_req(2'd2, 2'd2, 1'b0, 8'h00);
        step();
        REQ_VALID = 1'b0;
        chk("rej_err", 32'(ERR), 32'd1);
        chk("rej_done", 32'(DONE), 32'd0);
        chk("rej_e", 32'(E), 32'd0);
        chk("rej_i", 32'(I), 32'd0);
        chk("rej_ready", 32'(REQ_READY), 32'd1);
        step();
        chk("rej_err_pulse", 32'(ERR), 32'd0);
        chk("rej_e2", 32'(E), 32'd0);
        chk("rej_done2", 32'(DONE), 32'd0);
        $display("txn reject 2->2");

        // Back-to-back: VALID held, second request waits for READY
        drive_req(2'd1, 2'd0, 1'b0, 8'h00);
        step();
        drive_req(2'd0, 2'd2, 1'b1, 8'h03);
        chk("b2b_c1_e", 32'(E), 32'b0010);
        step();
        chk("b2b_c2_i", 32'(I), 32'b0001);
        chk("b2b_c2_oe", 32'(BUS_OE), 32'd0);
        step();
        chk("b2b_c3_done", 32'(DONE), 32'd1);
        chk("b2b_c3_ready", 32'(REQ_READY), 32'd0);
        step();
        chk("b2b_c4_ready", 32'(REQ_READY), 32'd1);
        chk("b2b_c4_oe", 32'(BUS_OE), 32'd0);
        chk("b2b_c4_e", 32'(E), 32'd0);
        step();
        REQ_VALID = 1'b0;
        chk("b2b_c5_oe", 32'(BUS_OE), 32'd1);
        chk("b2b_c5_bus", 32'(BUS_OUT), 32'h03);
        chk("b2b_c5_ready", 32'(REQ_READY), 32'd0);
        step();
        chk("b2b_c6_i", 32'(I), 32'b0100);
        step();
        chk("b2b_c7_done", 32'(DONE), 32'd1);
        chk("b2b_c7_data", 32'(XFER_DATA), 32'h03);
        $display("txn back-to-back second data=%02h", XFER_DATA);
        step();

        for (int t = 0; t < 8; t++) begin
            run_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Register-transfer initiator for the model computer's shared 8-bit internal bus.
- Accepts one transfer request at a time, either register-to-register or immediate-to-register.
- Sequences the one-hot output-enable strobes (E*, the EDR-style "drive bus" controls) and load strobes (I*, the IDR-style "latch from bus" controls) that the bus registers (DR and its peers) consume.
- Sits between the microcontroller/sequencer and the register file on the bus.

Parameters:
- DW, 8, bus data width.
- NREG, 4, number of bus registers addressed; index 0 is DR.
- SELW, 2, width of register select fields; NREG must be ≤ 2**SELW.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  controller can accept a request.
- REQ_SRC  input  SELW  source register index; ignored when REQ_IMM_EN=1.
- REQ_DST  input  SELW  destination register index.
- REQ_IMM_EN  input  1  1 = drive REQ_IMM onto the bus instead of a register.
- REQ_IMM  input  DW  immediate value.
- E  output  NREG  one-hot register output-enable strobes (E[i] drives register i onto the bus).
- I  output  NREG  one-hot register load strobes (I[i] loads register i from the bus on the next CLK rise).
- BUS_OUT  output  DW  immediate value driven by this block.
- BUS_OE  output  1  BUS_OUT valid on the bus.
- BUS_IN  input  DW  resolved bus value, observed.
- DONE  output  1  one-cycle pulse: transfer completed.
- ERR  output  1  one-cycle pulse: request rejected.
- XFER_DATA  output  DW  bus value captured during the last completed LOAD.

Behaviour:
- Reset (RST=1 at a CLK rise): state=IDLE, E=0, I=0, BUS_OE=0, BUS_OUT=0, DONE=0, ERR=0, XFER_DATA=0, REQ_READY=1 (after reset). Reset mid-transfer aborts immediately; no strobe is asserted in the cycle after reset.
- All outputs are registered. E, I and BUS_OE are never X after reset.
- FSM states are IDLE, DRIVE, LOAD, FIN.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID=1, latch src, dst, imm_en and imm.
  - Reject if any of the following holds: (imm_en=0 and src==dst), or src ≥ NREG (reg mode), or dst ≥ NREG. A rejected request pulses ERR the next cycle and stays in IDLE, with no strobes.
  - Otherwise go to DRIVE.
- DRIVE (1 cycle): REQ_READY=0.
  - Register mode: E[src]=1.
  - Immediate mode: BUS_OE=1, BUS_OUT=imm.
  - I=0; this cycle is bus settle.
- LOAD (1 cycle): same drive as DRIVE, plus I[dst]=1. At the end of the cycle, XFER_DATA <= BUS_IN.
- FIN (1 cycle): E=0, I=0, BUS_OE=0, DONE=1. Return to IDLE.
- Latency: request accepted at edge n → E/BUS_OE high in cycle n+1 → I high in cycle n+2 → DONE in cycle n+3 → REQ_READY high in cycle n+4. Throughput is 1 transfer per 4 cycles.
- Invariants:
  - At most one bit of E is high.
  - At most one bit of I is high.
  - E and BUS_OE are never both high.
  - I is only high while a driver is high.
- REQ_VALID while REQ_READY=0 is ignored (not queued); the initiator must hold REQ_VALID until it sees READY.
- DONE and ERR are never high in the same cycle.

Optional Feature:
- Macro: XFER_CNT_EN.
- Defined: adds output XFER_CNT [15:0], reset to 0, incremented in the FIN cycle. It wraps 16'hFFFF→0. Rejected requests do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RST 2 cycles mid-LOAD (E[1]=1, I[2]=1) → the next cycle has E=0, I=0, BUS_OE=0, DONE=0, REQ_READY=1, XFER_DATA=0.
- Reg transfer: SRC=1, DST=0, bus model returns 8'h05 when E[1] is high → cycle+1 E=4'b0010; cycle+2 I=4'b0001; XFER_DATA=8'h05; DONE in cycle+3.
- Immediate: IMM_EN=1, IMM=8'hFE, DST=3 → BUS_OE=1 with BUS_OUT=8'hFE for 2 cycles; I=4'b1000 in the 2nd of those; XFER_DATA=8'hFE.
- Reject: SRC=2, DST=2, IMM_EN=0 → ERR pulse one cycle later; E=I=0 throughout; REQ_READY stays 1; no DONE.
- Back-to-back: hold REQ_VALID with two requests (1→0 then imm 8'h03→2) → second accepted exactly 4 cycles after the first; no overlap of strobes; two DONE pulses.
- XFER_CNT_EN: preload via 65535 transfers (or force) → the next DONE wraps XFER_CNT to 0; a rejected request leaves the count unchanged.
